cav4_lorentz: RTL and testbench

CAV4_LORENTZ -- requirements
Module: cav4_lorentz

---
 rtl/cav4_lorentz_pkg.sv | 54 +++++
 rtl/cav4_lorentz_mac.sv | 52 +++++
 rtl/cav4_lorentz.sv | 194 +++++++++++++++++++
 tb/tb_cav4_lorentz.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cav4_lorentz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cav4_lorentz_pkg
// Purpose  : Shared constants, types and the saturation helper for the
//            cavity Lorentz-force detuning block.
// Revision : 1.0 - initial release
// ============================================================================
package cav4_lorentz_pkg;

    localparam int N_MECH_MODES = 7;
    localparam int N_CYCLES     = 2 * N_MECH_MODES;

    localparam int DATA_W    = 18;          // sample / coefficient width
    localparam int ACC_W     = 39;          // detune accumulator width
    localparam int PROD_W    = 2 * DATA_W;  // full 18x18 product width
    localparam int V2_W      = 17;          // unsigned field-power width
    localparam int ADDR_W    = 4;           // slot / table address width
    localparam int SHIFT_DRV = 17;          // product -> data scaling
    localparam int SHIFT_V2  = 18;          // |field|^2 -> v2 scaling

    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]  ACC_DATA_MAX = ACC_W'(DATA_MAX);
    localparam logic signed [ACC_W-1:0]  ACC_DATA_MIN = ACC_W'(DATA_MIN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                     clip;
        logic signed [DATA_W-1:0] val;
    } sat_t;

    // Clamp an accumulator-wide value into the signed data range and flag
    // whether clamping happened.
    function automatic sat_t sat_data(input logic signed [ACC_W-1:0] x);
        sat_t r;
        if (x > ACC_DATA_MAX) begin
            r.clip = 1'b1;
            r.val  = DATA_MAX;
        end else if (x < ACC_DATA_MIN) begin
            r.clip = 1'b1;
            r.val  = DATA_MIN;
        end else begin
            r.clip = 1'b0;
            r.val  = x[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cav4_lorentz_mac.sv
`default_nettype none
// ============================================================================
// Module   : lorentz_mac
// Purpose  : Registered signed 18x18 multiply with accumulate / replace
//            control. The output is the accumulator scaled down by SHIFT
//            and clamped to the 18-bit data range.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            i_en         - update the accumulator this cycle
//            i_accum      - 1: acc += a*b, 0: acc = a*b
//            i_a, i_b     - signed operands
//            o_q          - sat(acc >>> SHIFT)
//            o_sat        - o_q is clamped
// Revision : 1.0 - initial release
// ============================================================================
module lorentz_mac
    import cav4_lorentz_pkg::*;
#(
    parameter int SHIFT = SHIFT_DRV
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic                     i_accum,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_q,
    output logic                     o_sat
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W-1:0]  w_sh;
    logic signed [ACC_W-1:0]  r_acc;
    sat_t                     w_sat;

    assign w_prod = i_a * i_b;
    assign w_base = i_accum ? r_acc : '0;
    assign w_sh   = r_acc >>> SHIFT;
    assign w_sat  = sat_data(w_sh);
    assign o_q    = w_sat.val;
    assign o_sat  = w_sat.clip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_base + ACC_W'(w_prod);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cav4_lorentz.sv
`default_nettype none
// ============================================================================
// Module   : cav4_lorentz
// Purpose  : Lorentz-force detuning model. Computes the field power once
//            per resonator frame, drives each time-multiplexed mechanical
//            mode with power * coupling, and sums position * coupling over
//            the frame into a detuning value.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            start_eig           - frame strobe (slot 0)
//            field_i, field_q    - cavity field, streamed continuously
//            mech_x              - resonator position, slot k at t+k
//            cpl_we/addr/data    - host write port of the coupling table
//            eig_drive           - per-slot drive, slot k at t+k+2
//            detune/detune_valid - frame sum, valid at t+n_cycles+2
//            clip                - any saturation event
// Revision : 1.0 - initial release
// ============================================================================
module cav4_lorentz
    import cav4_lorentz_pkg::*;
#(
    parameter int n_mech_modes = N_MECH_MODES,
    parameter int n_cycles     = 2 * n_mech_modes
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_eig,
    input  logic signed [DATA_W-1:0] field_i,
    input  logic signed [DATA_W-1:0] field_q,
    input  logic signed [DATA_W-1:0] mech_x,
    input  logic                     cpl_we,
    input  logic [ADDR_W-1:0]        cpl_addr,
    input  logic signed [DATA_W-1:0] cpl_data,
    output logic signed [DATA_W-1:0] eig_drive,
    output logic signed [DATA_W-1:0] detune,
    output logic                     detune_valid,
    output logic                     clip
);

    localparam logic [ADDR_W-1:0] c_last_slot = ADDR_W'(n_cycles - 1);
    localparam logic [ADDR_W-1:0] c_depth     = ADDR_W'(n_cycles);

    // ---------------------------------------------------------------- slots
    state_t                   r_state;
    logic [ADDR_W-1:0]        r_cnt;
    logic [ADDR_W-1:0]        w_s;
    logic                     w_active;

    // The strobe cycle itself is slot 0, so the slot index is resolved
    // combinationally and r_cnt holds the index for the following cycle.
    assign w_active = start_eig || (r_state == ST_RUN);
    assign w_s      = start_eig ? '0 : r_cnt;

    // ------------------------------------------------------- field power
    logic signed [PROD_W-1:0] w_sq_i;
    logic signed [PROD_W-1:0] w_sq_q;
    logic [PROD_W-1:0]        r_sq_i;
    logic [PROD_W-1:0]        r_sq_q;
    logic [PROD_W:0]          w_pow;
    logic [PROD_W:0]          w_pow_sh;
    logic                     w_v2_sat;
    logic [V2_W-1:0]          w_v2;
    logic [V2_W-1:0]          r_v2;
    logic                     r_v2_sat;
    logic [V2_W-1:0]          r_v2_frame;

    assign w_sq_i   = field_i * field_i;
    assign w_sq_q   = field_q * field_q;
    // Squares are non-negative, so the sum is handled as unsigned.
    assign w_pow    = {1'b0, r_sq_i} + {1'b0, r_sq_q};
    assign w_pow_sh = w_pow >> SHIFT_V2;
    assign w_v2_sat = |w_pow_sh[PROD_W:V2_W];
    assign w_v2     = w_v2_sat ? {V2_W{1'b1}} : w_pow_sh[V2_W-1:0];

    // ------------------------------------------------------ coupling table
    logic signed [DATA_W-1:0] r_cpl_mem [n_cycles];
    logic signed [DATA_W-1:0] r_cpl_rd;

    // Table contents survive reset; only the host port writes them.
    always_ff @(posedge clk) begin
        if (cpl_we && (cpl_addr < c_depth)) begin
            r_cpl_mem[cpl_addr] <= cpl_data;
        end
    end

    // ------------------------------------------- alignment to table output
    logic signed [DATA_W-1:0] r_mx_d1;
    logic                     r_act_d1;
    logic                     r_first_d1;
    logic                     r_last_d1;
    logic                     r_last_d2;

    // ------------------------------------------------------------ MACs
    logic signed [DATA_W-1:0] w_drv_q;
    logic                     w_drv_sat;
    logic signed [DATA_W-1:0] w_det_q;
    logic                     w_det_sat;

    // Drive path: power is non-negative, zero-extended to a signed operand.
    lorentz_mac #(
        .SHIFT   (SHIFT_DRV)
    ) u_mac_drv (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_act_d1),
        .i_accum (1'b0),
        .i_a     ({1'b0, r_v2_frame}),
        .i_b     (r_cpl_rd),
        .o_q     (w_drv_q),
        .o_sat   (w_drv_sat)
    );

    // Detune path: slot 0 replaces the accumulator, which discards any
    // partial sum left by an abandoned frame.
    lorentz_mac #(
        .SHIFT   (SHIFT_DRV)
    ) u_mac_det (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_act_d1),
        .i_accum (!r_first_d1),
        .i_a     (r_mx_d1),
        .i_b     (r_cpl_rd),
        .o_q     (w_det_q),
        .o_sat   (w_det_sat)
    );

    assign eig_drive = w_drv_q;

    // ------------------------------------------------------ control / regs
    logic r_clip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_sq_i       <= '0;
            r_sq_q       <= '0;
            r_v2         <= '0;
            r_v2_sat     <= 1'b0;
            r_v2_frame   <= '0;
            r_cpl_rd     <= '0;
            r_mx_d1      <= '0;
            r_act_d1     <= 1'b0;
            r_first_d1   <= 1'b0;
            r_last_d1    <= 1'b0;
            r_last_d2    <= 1'b0;
            detune       <= '0;
            detune_valid <= 1'b0;
            r_clip       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start_eig) r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase

            if (w_active) begin
                r_cnt <= (w_s == c_last_slot) ? '0 : w_s + 1'b1;
            end

            r_sq_i   <= w_sq_i;
            r_sq_q   <= w_sq_q;
            r_v2     <= w_v2;
            r_v2_sat <= w_v2_sat;
            if (start_eig) begin
                r_v2_frame <= r_v2;
            end

            r_cpl_rd   <= r_cpl_mem[w_s];
            r_mx_d1    <= mech_x;
            r_act_d1   <= w_active;
            r_first_d1 <= w_active && (w_s == '0);
            // A frame that never reaches the last slot never raises this
            // marker, so an abandoned frame produces no detune_valid.
            r_last_d1  <= w_active && (w_s == c_last_slot);
            r_last_d2  <= r_last_d1;

            detune_valid <= r_last_d2;
            if (r_last_d2) begin
                detune <= w_det_q;
            end

            // Field-power clipping is reported when the clipped value is
            // latched for a frame, not on every streamed sample. The drive
            // term is bounded by construction and is kept only as a guard.
            r_clip <= (start_eig && r_v2_sat)
                    || (r_last_d2 && w_det_sat)
                    || w_drv_sat;
        end
    end

    assign clip = r_clip;

endmodule
`default_nettype wire

// File: tb/tb_cav4_lorentz.sv
`default_nettype none
// ============================================================================
// Module   : tb_cav4_lorentz
// Purpose  : Directed self-checking bench for cav4_lorentz.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cav4_lorentz;

    localparam int c_ncyc = 14;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_eig;
    logic signed [17:0] field_i;
    logic signed [17:0] field_q;
    logic signed [17:0] mech_x;
    logic               cpl_we;
    logic [3:0]         cpl_addr;
    logic signed [17:0] cpl_data;
    logic signed [17:0] eig_drive;
    logic signed [17:0] detune;
    logic               detune_valid;
    logic               clip;

    int n_checks = 0;
    int n_errors = 0;

    cav4_lorentz #(
        .n_mech_modes (7)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_eig    (start_eig),
        .field_i      (field_i),
        .field_q      (field_q),
        .mech_x       (mech_x),
        .cpl_we       (cpl_we),
        .cpl_addr     (cpl_addr),
        .cpl_data     (cpl_data),
        .eig_drive    (eig_drive),
        .detune       (detune),
        .detune_valid (detune_valid),
        .clip         (clip)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag,
                             input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_all(input logic signed [17:0] val);
        for (int i = 0; i < c_ncyc; i++) begin
            cpl_we   = 1'b1;
            cpl_addr = 4'(i);
            cpl_data = val;
            tick();
        end
        cpl_we = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start_eig = 1'b0;
        cpl_we    = 1'b0;
        cpl_addr  = '0;
        cpl_data  = '0;
        field_i   = '0;
        field_q   = '0;
        mech_x    = '0;
        tick(3);

        check_val("rst_drive", eig_drive, 0);
        check_val("rst_detune", detune, 0);
        check_val("rst_dv", detune_valid, 0);
        check_val("rst_clip", clip, 0);
        rst = 1'b0;

        // ---- idle with live inputs: no output activity
        field_i = 18'sd65536;
        field_q = 18'sd65536;
        mech_x  = 18'sd4096;
        write_all(18'sd65536);
        for (int i = 0; i < 6; i++) begin
            check_val("idle_drive", eig_drive, 0);
            check_val("idle_dv", detune_valid, 0);
            check_val("idle_clip", clip, 0);
            tick();
        end

        // ---- frame 1 at t: v2=32768, drive=16384, detune=14*4096/2=28672
        start_eig = 1'b1;
        tick();                                   // t+1
        start_eig = 1'b0;
        check_val("v2_noclip", clip, 0);
        tick();                                   // t+2
        check_val("drv_slot0", eig_drive, 16384);
        tick(11);                                 // t+13
        field_i = 18'sd32768;                     // after frame-2 power sample
        field_q = 18'sd32768;
        tick();                                   // t+14: back-to-back frame 2
        start_eig = 1'b1;
        mech_x    = 18'sd8192;
        tick();                                   // t+15
        start_eig = 1'b0;
        check_val("drv_slot13", eig_drive, 16384);
        check_val("dv_t15", detune_valid, 0);
        tick();                                   // t+16
        check_val("dv_t16", detune_valid, 1);
        check_val("det_sum", detune, 28672);
        check_val("det_noclip", clip, 0);
        check_val("drv_f2_slot0", eig_drive, 16384);
        tick();                                   // t+17
        check_val("dv_t17", detune_valid, 0);
        tick(3);                                  // t+20
        check_val("drv_v2_hold", eig_drive, 16384);
        tick(10);                                 // t+30
        check_val("dv_b2b", detune_valid, 1);
        check_val("det_b2b", detune, 57344);

        // ---- asynchronous reset in the middle of a cycle
        #2 rst = 1'b1;
        #1;
        check_val("arst_drive", eig_drive, 0);
        check_val("arst_detune", detune, 0);
        check_val("arst_dv", detune_valid, 0);
        check_val("arst_clip", clip, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_val("post_rst_drive", eig_drive, 0);
            check_val("post_rst_dv", detune_valid, 0);
            tick();
        end
        // table kept: v2 = 8192, drive = 8192*65536/2^17 = 4096
        start_eig = 1'b1;
        tick();
        start_eig = 1'b0;
        tick();
        check_val("drv_kept", eig_drive, 4096);

        // ---- detune saturation: 14 * 2^34 >>> 17 clamps to 131071
        pulse_rst();
        field_i = 18'sd65536;
        field_q = 18'sd65536;
        mech_x  = -18'sd131072;
        write_all(-18'sd131072);
        start_eig = 1'b1;
        tick();                                   // t+1
        start_eig = 1'b0;
        tick();                                   // t+2
        check_val("drv_neg", eig_drive, -32768);
        tick(13);                                 // t+15
        check_val("sat_clip_t15", clip, 0);
        tick();                                   // t+16
        check_val("sat_dv", detune_valid, 1);
        check_val("sat_detune", detune, 131071);
        check_val("sat_clip", clip, 1);
        tick();                                   // t+17
        check_val("sat_clip_t17", clip, 0);

        // ---- field-power saturation: I=Q=-131072 -> v2 clamps to 131071
        pulse_rst();
        field_i = -18'sd131072;
        field_q = -18'sd131072;
        mech_x  = '0;
        tick(3);
        check_val("v2_clip_t0", clip, 0);
        start_eig = 1'b1;
        tick();                                   // t+1
        start_eig = 1'b0;
        check_val("v2_clip", clip, 1);
        tick();                                   // t+2
        check_val("v2_clip_t2", clip, 0);
        check_val("drv_v2sat", eig_drive, -131071);
        tick(14);                                 // t+16
        check_val("v2_dv", detune_valid, 1);
        check_val("v2_detune", detune, 0);
        check_val("v2_det_noclip", clip, 0);

        // ---- mid-frame restarts
        pulse_rst();
        field_i = 18'sd65536;
        field_q = 18'sd65536;
        mech_x  = 18'sd4096;
        write_all(18'sd65536);
        start_eig = 1'b1;                         // t0
        tick();
        start_eig = 1'b0;
        tick(13);                                 // t0+14
        mech_x = 18'sd100000;
        tick(2);                                  // t0+16
        check_val("mid_pre_dv", detune_valid, 1);
        check_val("mid_pre_det", detune, 28672);
        tick(4);                                  // t1 = t0+20
        start_eig = 1'b1;
        tick();
        start_eig = 1'b0;
        tick(4);                                  // t1+5
        start_eig = 1'b1;
        mech_x    = 18'sd2048;
        tick();                                   // t1+6
        start_eig = 1'b0;
        for (int i = 6; i < 21; i++) begin
            check_val("mid_no_dv", detune_valid, 0);
            if (i == 16) check_val("mid_det_hold", detune, 28672);
            tick();
        end
        // t1+21: 14 * 2048 * 65536 >>> 17 = 14336
        check_val("mid_dv", detune_valid, 1);
        check_val("mid_detune", detune, 14336);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
